ntt_layer_ctrl: RTL and testbench

Sequencer that drives one butterfly unit through a complete in-place 256-point Kyber NTT or INTT held in a dual-port coefficient RAM. It produces the read addresses, the twiddle ROM address and the butterfly mode for each butterfly. It delays the addresses to match the read-plus-butterfly pipeline and issues the write-back. It sits between the host start/done handshake and the RAM, twiddle ROM and butterfly datapath.

---
 rtl/ntt_layer_ctrl.sv | 100 ++++++++++
 tb/tb_ntt_layer_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ntt_layer_ctrl.sv
// ntt_layer_ctrl: address/twiddle/write-back sequencer for an in-place 256-point Kyber NTT/INTT
module ntt_layer_ctrl #(
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       inv,
    output logic       busy,
    output logic       done,
    output logic [2:0] layer,
    output logic       rd_en,
    output logic [7:0] rd_addr_a,
    output logic [7:0] rd_addr_b,
    output logic [6:0] tw_addr,
    output logic [1:0] bf_mode,
    output logic       wr_en,
    output logic [7:0] wr_addr_a,
    output logic [7:0] wr_addr_b
);
    localparam int D = RD_LAT + BF_LAT;
    localparam int DW = $clog2(D) > 0 ? $clog2(D) : 1;
    localparam logic [DW-1:0] DLAST = DW'(D - 1);
    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FIN} state_t;
    state_t state, state_nx;
    logic inv_q;
    logic [6:0] cnt;
    logic [6:0] k;
    logic [DW-1:0] dcnt;
    logic [7:0] len, mask, addr_a;
    logic grp_end, drain_end;
    logic [16:0] sr [D];
    // butterfly index within the layer is split around the len bit to form j
    always_comb begin
        len = inv_q ? (8'd2 << layer) : (8'd128 >> layer);
        mask = len - 8'd1;
        addr_a = ((({1'b0, cnt}) & ~mask) << 1) | ({1'b0, cnt} & mask);
        grp_end = (({1'b0, cnt}) & mask) == mask;
        drain_end = dcnt == DLAST;
    end
    // state register
    always_ff @(posedge clk) begin
        if (rst_n) state <= IDLE;
        else state <= state_nx;
    end
    // next-state and handshake/read-side outputs
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  state_nx = start ? ISSUE : IDLE;
            ISSUE: state_nx = (cnt == 7'd127) ? DRAIN : ISSUE;
            DRAIN: state_nx = drain_end ? ((layer == 3'd6) ? FIN : ISSUE) : DRAIN;
            FIN:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        rd_en = state == ISSUE;
        busy = (state == ISSUE) || (state == DRAIN);
        done = state == FIN;
        rd_addr_a = rd_en ? addr_a : 8'd0;
        rd_addr_b = rd_en ? addr_a + len : 8'd0;
        tw_addr = k;
    end
    // layer, butterfly counter, twiddle index and drain counter
    always_ff @(posedge clk) begin
        if (rst_n) begin
            inv_q <= 1'b0;
            layer <= 3'd0;
            cnt <= 7'd0;
            k <= 7'd0;
            dcnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                inv_q <= inv;
                layer <= 3'd0;
                cnt <= 7'd0;
                k <= inv ? 7'd127 : 7'd1;
            end
            if (state == ISSUE) begin
                cnt <= cnt + 7'd1;
                if (grp_end) k <= inv_q ? k - 7'd1 : k + 7'd1;
            end
            dcnt <= (state == DRAIN) ? dcnt + 1'b1 : '0;
            if (state == DRAIN && drain_end && layer != 3'd6) layer <= layer + 3'd1;
        end
    end
    // write-back delay line carrying {valid, addr_a, addr_b} through the read and butterfly latency
    always_ff @(posedge clk) begin
        if (rst_n) begin
            for (int i = 0; i < D; i++) sr[i] <= '0;
        end else begin
            sr[0] <= {rd_en, rd_addr_a, rd_addr_b};
            for (int i = 1; i < D; i++) sr[i] <= sr[i-1];
        end
    end
    assign wr_en = sr[D-1][16];
    assign wr_addr_a = sr[D-1][15:8];
    assign wr_addr_b = sr[D-1][7:0];
    assign bf_mode = sr[RD_LAT-1][16] ? {1'b0, inv_q} : 2'b11;
endmodule

// File: tb/tb_ntt_layer_ctrl.sv
// tb_ntt_layer_ctrl: per-cycle check of ntt_layer_ctrl against a loop-level schedule model and a golden NTT
module tb_ntt_layer_ctrl;
    localparam int RD_LAT = 1, BF_LAT = 4, D = RD_LAT + BF_LAT, P = 128 + D, Q = 3329, FEND = 7 * P;
    logic clk = 0, rst_n = 1, start = 0, inv = 0;
    logic busy, done, rd_en, wr_en;
    logic [2:0] layer;
    logic [7:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
    logic [6:0] tw_addr;
    logic [1:0] bf_mode;
    always #5 clk = ~clk;
    ntt_layer_ctrl #(.RD_LAT(RD_LAT), .BF_LAT(BF_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .inv(inv),
        .busy(busy), .done(done), .layer(layer),
        .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
        .bf_mode(bf_mode), .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
    );
    int n_chk = 0, n_pass = 0, cyc = 0, t0 = 0, rd_cnt = 0, wr_cnt = 0, dr;
    bit chk_on = 0, ram_on = 0;
    int e_rd[1024], e_a[1024], e_b[1024], e_tw[1024], e_ly[1024];
    int e_wr[1024], e_wa[1024], e_wb[1024], e_mode[1024];
    int zeta[128], ram[256], gold[256];
    int qc[$], qd[$];
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string nm, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s rel=%0d got=%0d exp=%0d", nm, cyc - t0, got, exp);
    endtask
    // expected schedule straight from the group/inner loop description
    function automatic void build(input bit i);
        int k, len, idx, c;
        for (int n = 0; n < 1024; n++) begin
            e_rd[n] = 0; e_a[n] = 0; e_b[n] = 0; e_tw[n] = 0; e_ly[n] = 0;
            e_wr[n] = 0; e_wa[n] = 0; e_wb[n] = 0; e_mode[n] = 3;
        end
        k = i ? 127 : 1;
        for (int L = 0; L < 7; L++) begin
            len = i ? (2 << L) : (128 >> L);
            idx = 0;
            for (int g = 0; g < 256; g += 2 * len) begin
                for (int j = g; j < g + len; j++) begin
                    c = 1 + L * P + idx;
                    e_rd[c] = 1; e_a[c] = j; e_b[c] = j + len; e_tw[c] = k; e_ly[c] = L;
                    e_wr[c+D] = 1; e_wa[c+D] = j; e_wb[c+D] = j + len;
                    e_mode[c+RD_LAT] = i;
                    idx++;
                end
                k = i ? k - 1 : k + 1;
            end
        end
    endfunction
    function automatic int brv7(input int x);
        int r = 0;
        for (int b = 0; b < 7; b++) r = (r << 1) | ((x >> b) & 1);
        return r;
    endfunction
    function automatic void golden();
        int k = 1, t, z;
        for (int len = 128; len >= 2; len = len >> 1)
            for (int s = 0; s < 256; s += 2 * len) begin
                z = zeta[k];
                k++;
                for (int j = s; j < s + len; j++) begin
                    t = (z * gold[j+len]) % Q;
                    gold[j+len] = (gold[j] - t + Q) % Q;
                    gold[j] = (gold[j] + t) % Q;
                end
            end
    endfunction
    task automatic go(input bit i);
        build(i);
        rd_cnt = 0; wr_cnt = 0;
        t0 = cyc; inv = i; start = 1; chk_on = 1;
        @(negedge clk);
        start = 0;
    endtask
    task automatic wait_done(output int d);
        d = -1;
        for (int n = 0; n < 1100; n++) begin
            @(negedge clk);
            if (done) begin
                d = cyc - t0;
                break;
            end
        end
    endtask
    // per-cycle compare against the schedule, plus a RAM/butterfly model driven by the DUT addresses
    always @(negedge clk) begin
        int r, t;
        #1;
        if (chk_on) begin
            r = cyc - t0;
            if (r >= 1 && r <= FEND + 1) begin
                chk("busy", int'(busy), int'(r <= FEND));
                chk("done", int'(done), int'(r == FEND + 1));
                chk("rd_en", int'(rd_en), e_rd[r]);
                chk("wr_en", int'(wr_en), e_wr[r]);
                chk("bf_mode", int'(bf_mode), e_mode[r]);
                if (e_rd[r] != 0) begin
                    chk("rd_addr_a", int'(rd_addr_a), e_a[r]);
                    chk("rd_addr_b", int'(rd_addr_b), e_b[r]);
                    chk("tw_addr", int'(tw_addr), e_tw[r]);
                    chk("layer", int'(layer), e_ly[r]);
                end
                if (e_wr[r] != 0) begin
                    chk("wr_addr_a", int'(wr_addr_a), e_wa[r]);
                    chk("wr_addr_b", int'(wr_addr_b), e_wb[r]);
                end
            end
            if (rd_en) rd_cnt++;
            if (wr_en) wr_cnt++;
        end
        if (ram_on) begin
            if (wr_en) begin
                if (qc.size() == 0) chk("wr_queue", 0, 1);
                else begin
                    ram[wr_addr_a] = qc.pop_front();
                    ram[wr_addr_b] = qd.pop_front();
                end
            end
            if (rd_en) begin
                t = (zeta[tw_addr] * ram[rd_addr_b]) % Q;
                qc.push_back((ram[rd_addr_a] + t) % Q);
                qd.push_back((ram[rd_addr_a] - t + Q) % Q);
            end
        end
    end
    initial begin
        int s;
        for (int k = 0; k < 128; k++) begin
            zeta[k] = 1;
            for (int e = 0; e < brv7(k); e++) zeta[k] = (zeta[k] * 17) % Q;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_rd_en", int'(rd_en), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_a", int'(rd_addr_a), 0);
        chk("rst_rd_b", int'(rd_addr_b), 0);
        chk("rst_wr_a", int'(wr_addr_a), 0);
        chk("rst_wr_b", int'(wr_addr_b), 0);
        chk("rst_tw", int'(tw_addr), 0);
        chk("rst_layer", int'(layer), 0);
        chk("rst_bf_mode", int'(bf_mode), 3);
        rst_n = 0;
        build(0);
        chk("pin_a1", e_a[1], 0); chk("pin_b1", e_b[1], 128); chk("pin_tw1", e_tw[1], 1);
        chk("pin_a128", e_a[128], 127); chk("pin_b128", e_b[128], 255); chk("pin_tw128", e_tw[128], 1);
        chk("pin_wr6", e_wr[6], 1); chk("pin_wa6", e_wa[6], 0); chk("pin_wb6", e_wb[6], 128);
        chk("pin_l6a", e_a[799], 0); chk("pin_l6b", e_b[799], 2); chk("pin_l6tw", e_tw[799], 64);
        chk("pin_l6a2", e_a[800], 1); chk("pin_l6tw2", e_tw[800], 64);
        chk("pin_l6a3", e_a[801], 4); chk("pin_l6b3", e_b[801], 6); chk("pin_l6tw3", e_tw[801], 65);
        chk("pin_last_a", e_a[926], 253); chk("pin_last_b", e_b[926], 255); chk("pin_last_tw", e_tw[926], 127);
        s = 0;
        for (int n = 0; n < 1024; n++) s += e_rd[n];
        chk("pin_nrd", s, 896);
        build(1);
        chk("pin_i_b1", e_b[1], 2); chk("pin_i_tw1", e_tw[1], 127);
        chk("pin_i_a3", e_a[3], 4); chk("pin_i_b3", e_b[3], 6); chk("pin_i_tw3", e_tw[3], 126);
        chk("pin_i_b799", e_b[799], 128); chk("pin_i_tw799", e_tw[799], 1); chk("pin_i_tw926", e_tw[926], 1);
        chk("pin_i_mode2", e_mode[2], 1);
        for (int n = 0; n < 256; n++) begin
            ram[n] = int'($urandom_range(Q - 1, 0));
            gold[n] = ram[n];
        end
        golden();
        @(negedge clk);
        ram_on = 1;
        go(0);
        while (cyc - t0 < 50) @(negedge clk);
        start = 1; inv = 1;
        @(negedge clk);
        start = 0;
        wait_done(dr);
        chk("ntt_done_cycle", dr, FEND + 1);
        chk("ntt_rd_count", rd_cnt, 896);
        chk("ntt_wr_count", wr_cnt, 896);
        chk("ntt_queue_empty", qc.size(), 0);
        for (int n = 0; n < 256; n++) chk($sformatf("ntt_coef%0d", n), ram[n], gold[n]);
        ram_on = 0;
        @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        go(1);
        wait_done(dr);
        chk("intt_done_cycle", dr, FEND + 1);
        chk("intt_rd_count", rd_cnt, 896);
        @(negedge clk);
        go(0);
        while (cyc - t0 < 200) @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        chk_on = 0;
        chk("abort_rd_en", int'(rd_en), 0);
        chk("abort_wr_en", int'(wr_en), 0);
        chk("abort_bf_mode", int'(bf_mode), 3);
        chk("abort_busy", int'(busy), 0);
        chk("abort_layer", int'(layer), 0);
        repeat (6) begin
            @(negedge clk);
            chk("abort_wr_quiet", int'(wr_en), 0);
        end
        rst_n = 0;
        @(negedge clk);
        go(0);
        wait_done(dr);
        chk("restart_done_cycle", dr, FEND + 1);
        chk("restart_wr_count", wr_cnt, 896);
        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
